// File: rtl/mc_control_if.sv
// Control/handshake bundle between the multi-cycle sequencer (master)
// and the datapath, decode stage and memories (slave).
interface mc_control_if #(parameter int CWIDTH = 16);
  logic              c_i_start;
  logic              c_i_halt;
  logic              c_i_imem_ack;
  logic              c_i_dmem_ack;
  logic [5:0]        c_i_opcode;
  logic [5:0]        c_i_funct;
  logic              c_i_dec_ce;
  logic              c_i_zero;

  logic              c_o_imem_req;
  logic              c_o_dec_ce;
  logic              c_o_alu_ce;
  logic [3:0]        c_o_alu_op;
  logic              c_o_alu_src_imm;
  logic              c_o_imm_zext;
  logic              c_o_dmem_req;
  logic              c_o_dmem_we;
  logic              c_o_reg_we;
  logic              c_o_reg_dst_rd;
  logic              c_o_mem_to_reg;
  logic              c_o_pc_we;
  logic              c_o_pc_src_br;
  logic              c_o_busy;
  logic              c_o_trap;
  logic [CWIDTH-1:0] c_o_retired;

  modport master (
    input  c_i_start, c_i_halt, c_i_imem_ack, c_i_dmem_ack,
           c_i_opcode, c_i_funct, c_i_dec_ce, c_i_zero,
    output c_o_imem_req, c_o_dec_ce, c_o_alu_ce, c_o_alu_op,
           c_o_alu_src_imm, c_o_imm_zext, c_o_dmem_req, c_o_dmem_we,
           c_o_reg_we, c_o_reg_dst_rd, c_o_mem_to_reg, c_o_pc_we,
           c_o_pc_src_br, c_o_busy, c_o_trap, c_o_retired
  );

  modport slave (
    output c_i_start, c_i_halt, c_i_imem_ack, c_i_dmem_ack,
           c_i_opcode, c_i_funct, c_i_dec_ce, c_i_zero,
    input  c_o_imem_req, c_o_dec_ce, c_o_alu_ce, c_o_alu_op,
           c_o_alu_src_imm, c_o_imm_zext, c_o_dmem_req, c_o_dmem_we,
           c_o_reg_we, c_o_reg_dst_rd, c_o_mem_to_reg, c_o_pc_we,
           c_o_pc_src_br, c_o_busy, c_o_trap, c_o_retired
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky trap
// on rejected instructions and a wrapping retired-instruction counter.
module mc_control #(parameter int CWIDTH = 16) (
  input logic          c_clk,
  input logic          c_rst,
  mc_control_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {CL_RTYPE, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE, CL_IMM} iclass_t;
  typedef enum logic [3:0] {ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU} alu_op_t;

  state_t            state_q, state_d;
  iclass_t           cls_q, cls_d;
  alu_op_t           alu_op_q, alu_op_d;
  logic [CWIDTH-1:0] retired_q, retired_d;

  iclass_t dec_cls;
  alu_op_t dec_op;
  logic    dec_illegal;
  logic    retire;
  logic    alu_stage;

  logic imem_req, dec_ce, alu_ce, dmem_req, dmem_we, reg_we;
  logic reg_dst_rd, mem_to_reg, pc_we, pc_src_br;

  always_comb begin
    dec_cls     = CL_RTYPE;
    dec_op      = ALU_ADD;
    dec_illegal = 1'b0;
    case (bus.c_i_opcode)
      6'h00: begin
        case (bus.c_i_funct)
          6'h20:   dec_op = ALU_ADD;
          6'h22:   dec_op = ALU_SUB;
          6'h24:   dec_op = ALU_AND;
          6'h25:   dec_op = ALU_OR;
          6'h26:   dec_op = ALU_XOR;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h23:        dec_cls = CL_LOAD;
      6'h2B:        dec_cls = CL_STORE;
      6'h04: begin  dec_cls = CL_BEQ; dec_op = ALU_SUB; end
      6'h05: begin  dec_cls = CL_BNE; dec_op = ALU_SUB; end
      6'h08, 6'h09: dec_cls = CL_IMM;
      6'h0A: begin  dec_cls = CL_IMM; dec_op = ALU_SLT;  end
      6'h0B: begin  dec_cls = CL_IMM; dec_op = ALU_SLTU; end
      6'h0C: begin  dec_cls = CL_IMM; dec_op = ALU_AND;  end
      6'h0D: begin  dec_cls = CL_IMM; dec_op = ALU_OR;   end
      6'h0E: begin  dec_cls = CL_IMM; dec_op = ALU_XOR;  end
      default:      dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_op_d   = alu_op_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    dec_ce     = 1'b0;
    alu_ce     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    reg_dst_rd = 1'b0;
    mem_to_reg = 1'b0;
    pc_we      = 1'b0;
    pc_src_br  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.c_i_start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.c_i_imem_ack) begin
          dec_ce  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d    = dec_cls;
        alu_op_d = dec_op;
        state_d  = (!bus.c_i_dec_ce || dec_illegal) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        alu_ce = 1'b1;
        if (cls_q == CL_BEQ || cls_q == CL_BNE) begin
          pc_we     = 1'b1;
          pc_src_br = (cls_q == CL_BEQ) ? bus.c_i_zero : !bus.c_i_zero;
          retire    = 1'b1;
        end else if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (bus.c_i_dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        reg_dst_rd = (cls_q == CL_RTYPE);
        mem_to_reg = (cls_q == CL_LOAD);
        retire     = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    // Halt is only honoured on the retire cycle; otherwise keep fetching.
    if (retire) begin
      retired_d = retired_q + CWIDTH'(1);
      state_d   = bus.c_i_halt ? S_IDLE : S_FETCH;
    end
  end

  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      state_q   <= S_IDLE;
      cls_q     <= CL_RTYPE;
      alu_op_q  <= ALU_ADD;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      retired_q <= retired_d;
    end
  end

  // ALU controls stay valid from EXEC through WB so address/result paths settle.
  assign alu_stage = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  assign bus.c_o_imem_req    = imem_req;
  assign bus.c_o_dec_ce      = dec_ce;
  assign bus.c_o_alu_ce      = alu_ce;
  assign bus.c_o_alu_op      = alu_stage ? alu_op_q : 4'd0;
  assign bus.c_o_alu_src_imm = alu_stage && (cls_q == CL_IMM || cls_q == CL_LOAD || cls_q == CL_STORE);
  assign bus.c_o_imm_zext    = alu_stage && (cls_q == CL_IMM) &&
                               (alu_op_q == ALU_AND || alu_op_q == ALU_OR || alu_op_q == ALU_XOR);
  assign bus.c_o_dmem_req    = dmem_req;
  assign bus.c_o_dmem_we     = dmem_we;
  assign bus.c_o_reg_we      = reg_we;
  assign bus.c_o_reg_dst_rd  = reg_dst_rd;
  assign bus.c_o_mem_to_reg  = mem_to_reg;
  assign bus.c_o_pc_we       = pc_we;
  assign bus.c_o_pc_src_br   = pc_src_br;
  assign bus.c_o_busy        = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign bus.c_o_trap        = (state_q == S_TRAP);
  assign bus.c_o_retired     = retired_q;
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a table of single instructions with
// hand-computed timing/decode results plus reset, trap and wrap sequences.
module tb_mc_control;
  localparam int CW = 2;

  logic c_clk;
  logic c_rst;
  int   checks;
  int   failures;
  logic [CW-1:0] exp_retired;

  mc_control_if #(.CWIDTH(CW)) bus ();

  mc_control #(.CWIDTH(CW)) dut (
    .c_clk (c_clk),
    .c_rst (c_rst),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    int         imem_dly;
    int         dmem_dly;
    logic [3:0] alu_op;
    logic       src_imm;
    logic       zext;
    logic       reg_we;
    logic       dst_rd;
    logic       m2r;
    logic       dmem_we;
    logic       br;
    int         lat;
    int         dmem_cyc;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [17:0] outVec();
    return {bus.c_o_imem_req, bus.c_o_dec_ce, bus.c_o_alu_ce, bus.c_o_alu_op,
            bus.c_o_alu_src_imm, bus.c_o_imm_zext, bus.c_o_dmem_req, bus.c_o_dmem_we,
            bus.c_o_reg_we, bus.c_o_reg_dst_rd, bus.c_o_mem_to_reg, bus.c_o_pc_we,
            bus.c_o_pc_src_br, bus.c_o_busy, bus.c_o_trap};
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  task automatic setInputs(input logic [5:0] op, input logic [5:0] fn, input logic dce,
                           input logic z, input logic halt);
    bus.c_i_opcode = op;
    bus.c_i_funct  = fn;
    bus.c_i_dec_ce = dce;
    bus.c_i_zero   = z;
    bus.c_i_halt   = halt;
  endtask

  // Runs one instruction from IDLE with halt=1; called at a negedge in IDLE.
  task automatic applyStimulus(input vec_t v, input int idx);
    int imem_n = 0, dmem_n = 0, dec_n = 0, alu_n = 0, pc_n = 0, reg_n = 0;
    int dec_cyc = 0, alu_cyc = 0, lat = 0;
    logic [3:0] alu_op_s = 4'hF;
    logic src_s = 1'bx, zext_s = 1'bx, br_s = 1'bx, dst_s = 1'bx, m2r_s = 1'bx;
    logic dwe_s = 1'bx, busy_s = 1'b0;
    string t = $sformatf("v%0d", idx);
    setInputs(v.opcode, v.funct, 1'b1, v.zero, 1'b1);
    bus.c_i_start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge c_clk); #1;
      bus.c_i_start    = 1'b0;
      bus.c_i_imem_ack = (imem_n >= v.imem_dly);
      bus.c_i_dmem_ack = (dmem_n >= v.dmem_dly);
      @(negedge c_clk);
      if (bus.c_o_imem_req) imem_n++;
      if (bus.c_o_dmem_req) begin dmem_n++; dwe_s = bus.c_o_dmem_we; end
      if (bus.c_o_dec_ce) begin dec_n++; dec_cyc = cyc; end
      if (bus.c_o_alu_ce) begin
        alu_n++; alu_cyc = cyc;
        alu_op_s = bus.c_o_alu_op; src_s = bus.c_o_alu_src_imm; zext_s = bus.c_o_imm_zext;
      end
      if (bus.c_o_reg_we) begin reg_n++; dst_s = bus.c_o_reg_dst_rd; m2r_s = bus.c_o_mem_to_reg; end
      if (bus.c_o_pc_we) begin pc_n++; br_s = bus.c_o_pc_src_br; busy_s = bus.c_o_busy; lat = cyc; end
      if (bus.c_o_pc_we || bus.c_o_trap) break;
    end
    checkOutput({t, ".lat"},      32'(lat),      32'(v.lat));
    checkOutput({t, ".imem_n"},   32'(imem_n),   32'(v.imem_dly + 1));
    checkOutput({t, ".dec_cyc"},  32'(dec_cyc),  32'(v.imem_dly + 1));
    checkOutput({t, ".dec_n"},    32'(dec_n),    32'd1);
    checkOutput({t, ".alu_cyc"},  32'(alu_cyc),  32'(v.imem_dly + 3));
    checkOutput({t, ".alu_n"},    32'(alu_n),    32'd1);
    checkOutput({t, ".alu_op"},   32'(alu_op_s), 32'(v.alu_op));
    checkOutput({t, ".src_imm"},  32'(src_s),    32'(v.src_imm));
    checkOutput({t, ".zext"},     32'(zext_s),   32'(v.zext));
    checkOutput({t, ".pc_n"},     32'(pc_n),     32'd1);
    checkOutput({t, ".pc_br"},    32'(br_s),     32'(v.br));
    checkOutput({t, ".busy"},     32'(busy_s),   32'd1);
    checkOutput({t, ".reg_n"},    32'(reg_n),    32'(v.reg_we));
    if (v.reg_we) begin
      checkOutput({t, ".dst_rd"}, 32'(dst_s),    32'(v.dst_rd));
      checkOutput({t, ".m2r"},    32'(m2r_s),    32'(v.m2r));
    end
    checkOutput({t, ".dmem_n"},   32'(dmem_n),   32'(v.dmem_cyc));
    if (v.dmem_cyc > 0) checkOutput({t, ".dmem_we"}, 32'(dwe_s), 32'(v.dmem_we));
    exp_retired = exp_retired + 1'b1;
    @(negedge c_clk);
    checkOutput({t, ".idle_busy"}, 32'(bus.c_o_busy),    32'd0);
    checkOutput({t, ".retired"},   32'(bus.c_o_retired), 32'(exp_retired));
  endtask

  // Start an instruction and step n cycles; ends at the negedge of cycle n.
  task automatic startAndStep(input int n);
    bus.c_i_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge c_clk); #1;
      bus.c_i_start = 1'b0;
      @(negedge c_clk);
    end
  endtask

  initial begin
    int n_ret, last_cyc;
    logic seen;
    checks = 0; failures = 0; exp_retired = '0;
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 0, 0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 0, 0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 0, 0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[4]  = '{6'h00, 6'h26, 1'b0, 0, 0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[5]  = '{6'h23, 6'h3F, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1};
    vecs[6]  = '{6'h23, 6'h3F, 1'b0, 0, 3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 4};
    vecs[7]  = '{6'h2B, 6'h3F, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1};
    vecs[8]  = '{6'h2B, 6'h3F, 1'b0, 0, 1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 2};
    vecs[9]  = '{6'h04, 6'h3F, 1'b1, 0, 0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0};
    vecs[10] = '{6'h05, 6'h3F, 1'b1, 0, 0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0};
    vecs[11] = '{6'h04, 6'h3F, 1'b0, 0, 0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0};
    vecs[12] = '{6'h05, 6'h3F, 1'b0, 0, 0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0};
    vecs[13] = '{6'h08, 6'h3F, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[14] = '{6'h09, 6'h3F, 1'b0, 0, 0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[15] = '{6'h0A, 6'h3F, 1'b0, 0, 0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[16] = '{6'h0B, 6'h3F, 1'b0, 0, 0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[17] = '{6'h0C, 6'h3F, 1'b0, 0, 0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[18] = '{6'h0D, 6'h3F, 1'b0, 0, 0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[19] = '{6'h0E, 6'h3F, 1'b0, 0, 0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0};
    vecs[20] = '{6'h00, 6'h20, 1'b0, 2, 0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 0};

    c_rst = 1'b0;
    bus.c_i_start = 1'b0; bus.c_i_imem_ack = 1'b0; bus.c_i_dmem_ack = 1'b0;
    setInputs(6'h00, 6'h00, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("reset.outputs", 32'(outVec()), 32'd0);
    checkOutput("reset.retired", 32'(bus.c_o_retired), 32'd0);
    @(negedge c_clk); @(negedge c_clk);
    c_rst = 1'b1;
    @(negedge c_clk);
    checkOutput("idle.no_start", 32'(outVec()), 32'd0);

    // Five untaken BEQs back to back with halt low until the last one.
    $display("[TB] retire counter wrap sequence");
    setInputs(6'h04, 6'h00, 1'b1, 1'b0, 1'b0);
    bus.c_i_imem_ack = 1'b1; bus.c_i_dmem_ack = 1'b1; bus.c_i_start = 1'b1;
    n_ret = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge c_clk); #1;
      bus.c_i_start = 1'b0;
      bus.c_i_halt  = (n_ret >= 4);
      @(negedge c_clk);
      if (bus.c_o_pc_we) n_ret++;
      if (n_ret == 5) begin last_cyc = cyc; break; end
    end
    @(negedge c_clk);
    checkOutput("wrap.count", 32'(n_ret), 32'd5);
    checkOutput("wrap.cycles", 32'(last_cyc), 32'd15);
    checkOutput("wrap.busy", 32'(bus.c_o_busy), 32'd0);
    checkOutput("wrap.retired", 32'(bus.c_o_retired), 32'd1);
    exp_retired = 2'd1;

    $display("[TB] instruction table");
    for (int i = 0; i < 21; i++) applyStimulus(vecs[i], i);

    // Asynchronous reset in the middle of a stalled data access.
    $display("[TB] reset during MEM");
    setInputs(6'h23, 6'h00, 1'b1, 1'b0, 1'b0);
    bus.c_i_imem_ack = 1'b1; bus.c_i_dmem_ack = 1'b0; bus.c_i_start = 1'b1;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge c_clk); #1;
      bus.c_i_start = 1'b0;
      @(negedge c_clk);
      if (bus.c_o_dmem_req) begin seen = 1'b1; break; end
    end
    checkOutput("rstmem.req_seen", 32'(seen), 32'd1);
    checkOutput("rstmem.retired_before", 32'(bus.c_o_retired), 32'(exp_retired));
    #2 c_rst = 1'b0;
    #1;
    checkOutput("rstmem.outputs", 32'(outVec()), 32'd0);
    checkOutput("rstmem.retired", 32'(bus.c_o_retired), 32'd0);
    exp_retired = '0;
    bus.c_i_dmem_ack = 1'b1;
    @(negedge c_clk);
    c_rst = 1'b1;
    @(negedge c_clk); @(negedge c_clk);
    checkOutput("rstmem.no_pending", 32'(outVec()), 32'd0);

    $display("[TB] trap on rejected opcode");
    setInputs(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
    startAndStep(1);
    checkOutput("trap1.dec_ce", 32'(bus.c_o_dec_ce), 32'd1);
    @(posedge c_clk); @(negedge c_clk);
    @(posedge c_clk); @(negedge c_clk);
    checkOutput("trap1.state", 32'(outVec()), 32'd1);
    startAndStep(3);
    checkOutput("trap1.start_ignored", 32'(outVec()), 32'd1);
    checkOutput("trap1.retired", 32'(bus.c_o_retired), 32'd0);
    #2 c_rst = 1'b0;
    #1;
    checkOutput("trap1.reset_clears", 32'(outVec()), 32'd0);
    @(negedge c_clk);
    c_rst = 1'b1;

    $display("[TB] trap on bad R-type funct");
    setInputs(6'h00, 6'h27, 1'b1, 1'b0, 1'b0);
    startAndStep(3);
    checkOutput("trap2.state", 32'(outVec()), 32'd1);
    #2 c_rst = 1'b0;
    #1;
    checkOutput("trap2.reset_clears", 32'(outVec()), 32'd0);
    @(negedge c_clk);
    c_rst = 1'b1;
    @(negedge c_clk);
    checkOutput("trap2.idle_after", 32'(outVec()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the decode-stage enable, the ALU, the register-file write, the PC update and the memory request handshakes. It consumes the registered opcode/funct/valid outputs of the decode stage and the ALU zero flag, and traps on any instruction the decoder rejects.

## Interface
- CWIDTH, 16, width of the retired-instruction counter
- c_clk  in  1  clock, all state changes on rising edge
- c_rst  in  1  asynchronous, active-low reset
- c_i_start  in  1  leave IDLE and begin fetching
- c_i_halt  in  1  sampled on retire cycle; 1 returns to IDLE instead of FETCH
- c_i_imem_ack  in  1  instruction memory has valid data this cycle
- c_i_dmem_ack  in  1  data memory access complete this cycle
- c_i_opcode  in  6  registered opcode from decode stage
- c_i_funct  in  6  registered funct from decode stage
- c_i_dec_ce  in  1  decode-stage valid (0 = unsupported opcode)
- c_i_zero  in  1  ALU result == 0
- c_o_imem_req  out  1  instruction fetch request, held until ack
- c_o_dec_ce  out  1  enable to decode stage (latch instruction)
- c_o_alu_ce  out  1  ALU evaluate
- c_o_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU
- c_o_alu_src_imm  out  1  ALU operand B = immediate
- c_o_imm_zext  out  1  zero-extend immediate (else sign-extend)
- c_o_dmem_req  out  1  data memory request, held until ack
- c_o_dmem_we  out  1  data memory write (valid with dmem_req)
- c_o_reg_we  out  1  register-file write strobe
- c_o_reg_dst_rd  out  1  write address rd (1) or rt (0)
- c_o_mem_to_reg  out  1  write-back data from memory
- c_o_pc_we  out  1  PC update strobe
- c_o_pc_src_br  out  1  PC := branch target (else PC+4)
- c_o_busy  out  1  state not IDLE and not TRAP
- c_o_trap  out  1  sticky illegal-instruction flag
- c_o_retired  out  CWIDTH  count of completed instructions, wraps

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state register plus a registered instruction class (RTYPE, LOAD, STORE, BRANCH-EQ, BRANCH-NE, IMM) and alu_op.
- Outputs are Moore decodes of the state and the class register. All outputs are 0 in IDLE and TRAP except c_o_trap=1 in TRAP.
- IDLE: if c_i_start, go to FETCH.
- FETCH: c_o_imem_req=1. On c_i_imem_ack: c_o_dec_ce=1 in that same cycle, then go to DECODE. Without ack, stay.
- DECODE: class and alu_op are registered from c_i_opcode/c_i_funct.
  - If c_i_dec_ce=0, or the instruction is RTYPE with funct not in {20h,22h,24h,25h,26h}, go to TRAP.
  - Otherwise go to EXEC.
- Opcode values: RTYPE 00h, LOAD 23h, STORE 2Bh, BEQ 04h, BNE 05h, ADDI 08h, ADDIU 09h, SLTI 0Ah, SLTIU 0Bh, ANDI 0Ch, ORI 0Dh, XORI 0Eh.
- alu_op mapping:
  - RTYPE funct 20h→ADD, 22h→SUB, 24h→AND, 25h→OR, 26h→XOR.
  - ADDI/ADDIU, LOAD, STORE→ADD.
  - SLTI→SLT; SLTIU→SLTU.
  - ANDI→AND, ORI→OR, XORI→XOR.
  - BEQ/BNE→SUB.
- Immediate control: c_o_alu_src_imm=1 for all non-RTYPE non-branch classes. c_o_imm_zext=1 only for ANDI/ORI/XORI.
- EXEC: c_o_alu_ce=1.
  - Branch class: c_o_pc_we=1 this cycle, and the instruction retires here. c_o_pc_src_br = (BEQ & c_i_zero) | (BNE & ~c_i_zero).
  - LOAD/STORE go to MEM; all other classes go to WB.
- MEM: c_o_dmem_req=1, with c_o_dmem_we=1 for STORE.
  - On ack, LOAD goes to WB.
  - On ack, STORE retires (c_o_pc_we=1).
  - Without ack, stay.
- WB: c_o_reg_we=1 and c_o_pc_we=1 (PC+4); the instruction retires here. c_o_reg_dst_rd=1 for RTYPE; c_o_mem_to_reg=1 for LOAD.
- Retire cycle: c_o_retired increments by 1 mod 2^CWIDTH. Next state is IDLE if c_i_halt=1, else FETCH.
- TRAP: terminal. Only reset exits it; c_i_start is ignored.

## Timing
- Reset (asynchronous, any state): state=IDLE, class/alu_op=0, c_o_retired=0, every output 0 immediately, no pending request kept.
- Latency with same-cycle acks, from FETCH entry to retire inclusive:
  - ALU/immediate: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Branch: 3 cycles.
- Each cycle an ack is low adds one cycle in FETCH or MEM.
- imem_req/dmem_req stay high continuously until the ack cycle and drop the next cycle. Acks are ignored when the matching request is low.
- c_o_dec_ce, c_o_alu_ce, c_o_reg_we and c_o_pc_we are single-cycle pulses, once per instruction.
- c_i_start while busy is ignored. c_i_halt is sampled only on the retire cycle.

## Test plan
- Reset, then start with ADD (op 00h, funct 20h) and acks tied high → dec_ce at cycle 1, alu_ce at cycle 3 with alu_op=0, reg_we+pc_we+reg_dst_rd at cycle 4, retired=1.
- LOAD (23h) with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0, then WB with mem_to_reg=1, reg_dst_rd=0; total 8 cycles.
- BEQ with zero=1, then BNE with zero=1 → pc_src_br=1 then 0, pc_we in EXEC, reg_we never asserted, retired=2.
- ORI (0Dh) → alu_op=3, alu_src_imm=1, imm_zext=1; SLTI (0Ah) → alu_op=5, imm_zext=0.
- dec_ce=0 in DECODE (opcode 3Fh) → TRAP, trap=1, busy=0, start pulse ignored; RTYPE funct 27h also traps; reset clears trap.
- Assert reset during MEM with dmem_req high → all outputs 0 at once; CWIDTH=2 with 5 retirements → retired=1; halt=1 on retire → IDLE, busy=0.
